key_event_queue: RTL and testbench
==================================

# key_event_queue

Sits directly downstream of the per-key debouncers. Takes their level outputs and single-cycle press/release pulses for four keys, and adds hold-to-repeat events. All events are serialised into a 4-deep FWFT queue that game/VGA control logic drains with a valid/ready handshake. Simultaneous events on several keys are never lost while queue space exists; loss is flagged.

## Interface
- REPEAT_DELAY, 24'd12_500_000, hold cycles from press to first repeat event (250 ms @ 50 MHz); must be ≥2
- REPEAT_PERIOD, 24'd5_000_000, cycles between subsequent repeat events; must be ≥2
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- key_state  in  4  debounced level per key, 1 = held
- key_pressed  in  4  one-cycle press pulse per key
- key_released  in  4  one-cycle release pulse per key
- event_ready  in  1  consumer accepts head event this cycle
- event_valid  out  1  queue non-empty
- event_key  out  2  key index of head event; 0 when empty
- event_type  out  2  head event type: 01 press, 10 release, 11 repeat; 00 when empty
- fifo_count  out  3  occupancy, 0..4
- overflow  out  1  sticky: an event was dropped

## Operation
- Per key, three pending flags: P (press), R (release), T (repeat).
- key_pressed[k] sets P[k], clears the repeat counter, and sets phase to 0.
- key_released[k] sets R[k] and clears T[k]. A stale repeat is never emitted after a release.
- Repeat generator, per key:
  - 24-bit counter plus a phase bit.
  - While key_state[k]=0: counter=0, phase=0.
  - While key_state[k]=1 and no press pulse: counter increments.
  - Phase 0: counter==REPEAT_DELAY-1 sets T[k], counter←0, phase←1.
  - Phase 1: counter==REPEAT_PERIOD-1 sets T[k], counter←0.
  - Repeat onto an already-set T coalesces silently; no overflow.
- Selector, each cycle:
  - Picks the lowest-index key with any pending flag.
  - Within a key: P > R > T.
  - Selected event is written to the FIFO iff fifo_count<4 (count before this cycle), and its flag is cleared.
  - No write when count==4, even if a read occurs the same cycle.
- Set and clear of the same flag in one cycle: set wins, so the flag stays 1.
- overflow←1 when a press/release pulse arrives for a flag already set that is not being cleared that cycle. Cleared only by reset.
- FIFO:
  - 4 entries of {key[1:0], type[1:0]}; circular read/write pointers with 2-bit wrap.
  - Read when event_valid & event_ready.
  - Write and read in the same cycle: count unchanged.
- Outputs are FWFT: event_key/event_type show the head entry while event_valid=1, else 0.

## Timing
- Reset values: event_valid 0, event_key 0, event_type 00, fifo_count 0, overflow 0, all flags 0, counters 0, phase 0, pointers 0.
- Latency from pulse to queue:
  - Pulse sampled at edge E sets its flag.
  - With no contention and free space, the event is written at edge E+1.
  - event_valid is high in the cycle after E+1.
- Contention: each additional pending event ahead in priority adds one cycle.
- Repeat timing: with the press pulse at edge E and key held, T is set at edge E+REPEAT_DELAY, then every REPEAT_PERIOD edges after that.
- Handshake:
  - event_valid never depends combinationally on event_ready.
  - The head is stable until consumed.
  - Dequeue takes effect at the edge where valid & ready.
- Reset mid-operation: queue, flags, counters and overflow all clear at that edge. Keys still held restart in phase 0 only on their next press pulse; until then the counter runs from 0 in phase 0.

## Test plan
- Single press: key_pressed=4'b0001 for 1 cycle at edge E → event_valid=1 after E+1, key=0, type=01. With event_ready=1, fifo_count returns to 0 one cycle later.
- Simultaneous pulses: key_pressed=4'b0101 in one cycle, event_ready=1 → queue outputs (0,01) then (2,01) on consecutive cycles; overflow stays 0.
- Auto-repeat (REPEAT_DELAY=10, REPEAT_PERIOD=4):
  - Press key 1, then hold key_state[1]=1 → (1,01), then (1,11) written at E+11, E+15, E+19.
  - Then pulse key_released[1] → (1,10), and no further repeat events.
- Backpressure (event_ready=0):
  - Five press pulses on key 3, spaced 3 cycles apart → fifo_count reaches 4.
  - The 5th event stays pending in P[3].
  - A 6th pulse while P[3] is still set → overflow=1.
  - Drain → exactly 5 events (3,01) delivered.
- Release cancels repeat: with T[2] pending behind a full FIFO, pulse key_released[2] → only (2,10) is later emitted for key 2, no (2,11).
- Reset mid-operation: FIFO holding 3 events, overflow=1, assert reset for 1 cycle → all outputs 0 at the next cycle. The next press is delivered normally with 2-cycle latency.

Source files
------------

// File: rtl/key_event_queue.sv
// Key event queue: turns per-key press/release pulses plus hold-to-repeat into a
// serialised stream of {key, type} events behind a 4-deep first-word-fall-through FIFO.
module key_event_queue #(
  parameter logic [23:0] REPEAT_DELAY  = 24'd12_500_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_state,
  input  logic [3:0] key_pressed,
  input  logic [3:0] key_released,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [1:0] event_key,
  output logic [1:0] event_type,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam logic [1:0] TypePress   = 2'b01;
  localparam logic [1:0] TypeRelease = 2'b10;
  localparam logic [1:0] TypeRepeat  = 2'b11;

  // Pending event flags per key
  logic [3:0] p_q, p_d, r_q, r_d, t_q, t_d;
  logic       overflow_q, overflow_d;

  // Repeat generator state
  logic [23:0] cnt_q [4];
  logic [23:0] cnt_d [4];
  logic [3:0]  phase_q, phase_d;
  logic [3:0]  rpt_set;

  // Selector results
  logic       sel_valid;
  logic [1:0] sel_key;
  logic [1:0] sel_type;
  logic [3:0] sel_onehot;
  logic [3:0] clr_p, clr_r, clr_t;
  logic       wr_en, rd_en;

  // FIFO storage
  logic [3:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;

  // Repeat counters: a press pulse restarts the delay phase, a released key idles
  always_comb begin
    rpt_set = '0;
    phase_d = phase_q;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (key_pressed[k]) begin
        cnt_d[k]   = '0;
        phase_d[k] = 1'b0;
      end else if (!key_state[k]) begin
        cnt_d[k]   = '0;
        phase_d[k] = 1'b0;
      end else if (!phase_q[k]) begin
        if (cnt_q[k] == REPEAT_DELAY - 24'd1) begin
          rpt_set[k] = 1'b1;
          cnt_d[k]   = '0;
          phase_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + 24'd1;
        end
      end else begin
        if (cnt_q[k] == REPEAT_PERIOD - 24'd1) begin
          rpt_set[k] = 1'b1;
          cnt_d[k]   = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 24'd1;
        end
      end
    end
  end

  // Pick lowest-index key with work pending; press beats release beats repeat
  always_comb begin
    sel_valid = 1'b0;
    sel_key   = 2'd0;
    sel_type  = 2'b00;
    // Descending scan so the lowest index is the last assignment and wins
    for (int k = 3; k >= 0; k--) begin
      if (p_q[k] || r_q[k] || t_q[k]) begin
        sel_valid = 1'b1;
        sel_key   = k[1:0];
        if (p_q[k])      sel_type = TypePress;
        else if (r_q[k]) sel_type = TypeRelease;
        else             sel_type = TypeRepeat;
      end
    end
    wr_en      = sel_valid && (count_q < 3'd4);
    sel_onehot = 4'b0001 << sel_key;
    clr_p      = (wr_en && sel_type == TypePress)   ? sel_onehot : 4'b0000;
    clr_r      = (wr_en && sel_type == TypeRelease) ? sel_onehot : 4'b0000;
    clr_t      = (wr_en && sel_type == TypeRepeat)  ? sel_onehot : 4'b0000;
  end

  // Flag update: new pulses override a same-cycle clear; release kills any pending repeat
  always_comb begin
    p_d        = (p_q & ~clr_p) | key_pressed;
    r_d        = (r_q & ~clr_r) | key_released;
    t_d        = ((t_q & ~clr_t) | rpt_set) & ~key_released;
    overflow_d = overflow_q
               | (|(key_pressed & p_q & ~clr_p))
               | (|(key_released & r_q & ~clr_r));
  end

  assign rd_en = event_valid && event_ready;

  // Flags, repeat generators, pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q        <= '0;
      r_q        <= '0;
      t_q        <= '0;
      overflow_q <= 1'b0;
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      p_q        <= p_d;
      r_q        <= r_d;
      t_q        <= t_d;
      overflow_q <= overflow_d;
      phase_q    <= phase_d;
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
      if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, wr_en} - {2'b00, rd_en};
    end
  end

  // FIFO payload; contents are only observed while valid, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {sel_key, sel_type};
  end

  assign event_valid = (count_q != 3'd0);
  assign event_key   = event_valid ? mem_q[rd_ptr_q][3:2] : 2'b00;
  assign event_type  = event_valid ? mem_q[rd_ptr_q][1:0] : 2'b00;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: per-cycle vector table plus multi-cycle sequences.
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_state, key_pressed, key_released;
  logic       event_ready;
  logic       event_valid;
  logic [1:0] event_key, event_type;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_queue #(
    .REPEAT_DELAY (24'd10),
    .REPEAT_PERIOD(24'd4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_state   (key_state),
    .key_pressed (key_pressed),
    .key_released(key_released),
    .event_ready (event_ready),
    .event_valid (event_valid),
    .event_key   (event_key),
    .event_type  (event_type),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ks, kp, kr;
    logic       rdy, rst;
    logic       v;
    logic [1:0] k, t;
    logic [2:0] c;
    logic       o;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] ks, input logic [3:0] kp, input logic [3:0] kr,
                              input logic rdy, input logic rst, input logic v,
                              input logic [1:0] k, input logic [1:0] t, input logic [2:0] c,
                              input logic o);
    vec_t r;
    r.ks = ks; r.kp = kp; r.kr = kr; r.rdy = rdy; r.rst = rst;
    r.v = v; r.k = k; r.t = t; r.c = c; r.o = o;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge
  task automatic step(input logic [3:0] ks, input logic [3:0] kp, input logic [3:0] kr,
                      input logic rdy, input logic rst);
    key_state    = ks;
    key_pressed  = kp;
    key_released = kr;
    event_ready  = rdy;
    reset        = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_ev;
    logic [3:0] got [$];
    logic [3:0] exp_ev [6];

    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    //          ks    kp    kr   rdy rst   v  k  t  c  o
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 1,  0, 0, 0, 0, 0)); // reset state
    vecs.push_back(mk(4'h1, 4'h1, 4'h0, 1, 0,  0, 0, 0, 0, 0)); // press key 0
    vecs.push_back(mk(4'h1, 4'h0, 4'h0, 1, 0,  1, 0, 1, 1, 0));
    vecs.push_back(mk(4'h1, 4'h0, 4'h0, 1, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h1, 1, 0,  0, 0, 0, 0, 0)); // release key 0
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0,  1, 0, 2, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h5, 4'h0, 1, 0,  0, 0, 0, 0, 0)); // keys 0 and 2 together
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0,  1, 0, 1, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0,  1, 2, 1, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h2, 4'h2, 0, 0,  0, 0, 0, 0, 0)); // press+release key 1
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0,  1, 1, 1, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0,  1, 1, 1, 2, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0,  1, 1, 2, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h1, 4'h0, 0, 0,  0, 0, 0, 0, 0)); // re-press while flag clears
    vecs.push_back(mk(4'h0, 4'h1, 4'h0, 0, 0,  1, 0, 1, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0,  1, 0, 1, 2, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0,  1, 0, 1, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 0,  0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].ks, vecs[i].kp, vecs[i].kr, vecs[i].rdy, vecs[i].rst);
      check($sformatf("vec%0d valid", i), event_valid, vecs[i].v);
      check($sformatf("vec%0d key", i), event_key, vecs[i].k);
      check($sformatf("vec%0d type", i), event_type, vecs[i].t);
      check($sformatf("vec%0d count", i), fifo_count, vecs[i].c);
      check($sformatf("vec%0d overflow", i), overflow, vecs[i].o);
    end

    // Auto-repeat on key 1: events written at E+1 (press), E+11, E+15, E+19 (repeat)
    step(4'h2, 4'h2, 4'h0, 1'b1, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      logic exp_v;
      step(4'h2, 4'h0, 4'h0, 1'b1, 1'b0);
      exp_v = (n == 1) || (n == 11) || (n == 15) || (n == 19);
      check($sformatf("rpt E+%0d valid", n), event_valid, exp_v);
      if (exp_v) begin
        check($sformatf("rpt E+%0d key", n), event_key, 1);
        check($sformatf("rpt E+%0d type", n), event_type, (n == 1) ? 1 : 3);
      end
    end
    step(4'h0, 4'h0, 4'h2, 1'b1, 1'b0);
    check("rpt release valid0", event_valid, 0);
    step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    check("rpt release valid", event_valid, 1);
    check("rpt release key", event_key, 1);
    check("rpt release type", event_type, 2);
    for (int n = 0; n < 10; n++) begin
      step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      check($sformatf("rpt quiet %0d", n), event_valid, 0);
    end
    check("rpt overflow", overflow, 0);

    // Backpressure: five presses on key 3 fill the queue, sixth overflows
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'h0, 4'h8, 4'h0, 1'b0, 1'b0);
      step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      check($sformatf("bp count after press %0d", i), fifo_count, (i < 4) ? i + 1 : 4);
      step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    end
    check("bp full count", fifo_count, 4);
    check("bp no overflow yet", overflow, 0);
    step(4'h0, 4'h8, 4'h0, 1'b0, 1'b0);
    check("bp overflow", overflow, 1);
    n_ev = 0;
    for (int n = 0; n < 20; n++) begin
      if (event_valid) begin
        n_ev++;
        check($sformatf("bp drain key %0d", n), event_key, 3);
        check($sformatf("bp drain type %0d", n), event_type, 1);
      end
      step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    end
    check("bp drained events", n_ev, 5);
    check("bp drained count", fifo_count, 0);

    // Reset mid-operation with three queued events and overflow set
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h0, 4'h7, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h2, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    check("rst pre count", fifo_count, 3);
    check("rst pre overflow", overflow, 1);
    check("rst pre head type", event_type, 1);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    check("rst valid", event_valid, 0);
    check("rst key", event_key, 0);
    check("rst type", event_type, 0);
    check("rst count", fifo_count, 0);
    check("rst overflow", overflow, 0);
    step(4'h0, 4'h8, 4'h0, 1'b0, 1'b0);
    check("rst press latency1", event_valid, 0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    check("rst press valid", event_valid, 1);
    check("rst press key", event_key, 3);
    check("rst press type", event_type, 1);
    check("rst press count", fifo_count, 1);

    // Release cancels a repeat that is stuck behind a full queue
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h4, 4'h7, 4'h3, 1'b0, 1'b0);
    for (int n = 1; n <= 11; n++) step(4'h4, 4'h0, 4'h0, 1'b0, 1'b0);
    check("rc full", fifo_count, 4);
    step(4'h0, 4'h0, 4'h4, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      if (event_valid) got.push_back({event_key, event_type});
      step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    end
    exp_ev[0] = 4'b00_01; exp_ev[1] = 4'b00_10; exp_ev[2] = 4'b01_01;
    exp_ev[3] = 4'b01_10; exp_ev[4] = 4'b10_01; exp_ev[5] = 4'b10_10;
    check("rc event count", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check($sformatf("rc event %0d", i), got[i], exp_ev[i]);
      else check($sformatf("rc event %0d missing", i), -1, exp_ev[i]);
    end
    check("rc overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
